// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator.
// All channels share one period counter. Each channel has a pending (shadow)
// duty and an active duty; shadow is copied to active only at the period
// boundary, so the waveform within a period never glitches. Shadow duty is
// changed by debounced increment/decrement buttons or by a direct host load.
module pwm_multi_channel #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 8,
  parameter int PERIOD         = 99,
  parameter int STEP           = 10,
  parameter int INIT_DUTY      = 50,
  parameter int DEBOUNCE_TICKS = 25000000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TW            = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              increase_duty,
  input  logic              decrease_duty,
  input  logic              load_en,
  input  logic [CNT_W-1:0]  load_duty,
  input  logic              center_mode,
  output logic [NUM_CH-1:0] PWM_OUT,
  output logic [CNT_W-1:0]  duty_rd,
  output logic              period_start
);

  localparam logic [CNT_W:0]   MAX_DUTY_W = (CNT_W+1)'(PERIOD + 1);
  localparam logic [CNT_W-1:0] MAX_DUTY   = CNT_W'(PERIOD + 1);
  localparam logic [CNT_W:0]   STEP_W     = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] PMAX       = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] INIT_D     = CNT_W'(INIT_DUTY);
  localparam logic [TW-1:0]    TICK_LAST  = TW'(DEBOUNCE_TICKS - 1);

  // Debounce tick generator and button sampling flops
  logic [TW-1:0] tick_cnt_q;
  logic          tick_s;
  logic          inc_s1_q, inc_s2_q, dec_s1_q, dec_s2_q;
  logic          inc_press_s, dec_press_s;

  // Duty storage, counter and mode
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              mode_q, mode_d;
  logic              boundary_s;

  // Write path helpers
  logic              sel_ok_s;
  logic [CNT_W-1:0]  cur_s;
  logic [CNT_W:0]    sum_s;
  logic [CNT_W-1:0]  wr_val_s;
  logic              wr_en_s;

  // Registered outputs
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [CNT_W-1:0]  duty_rd_q;
  logic              period_start_q;

  assign tick_s      = (tick_cnt_q == TICK_LAST);
  assign inc_press_s = inc_s1_q & ~inc_s2_q & tick_s;
  assign dec_press_s = dec_s1_q & ~dec_s2_q & tick_s;
  assign boundary_s  = (cnt_q == '0);

  // Free-running debounce sample counter, one tick per wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick_s) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Two-stage button samplers, advanced only on the debounce tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_s1_q <= 1'b0;
      inc_s2_q <= 1'b0;
      dec_s1_q <= 1'b0;
      dec_s2_q <= 1'b0;
    end else if (tick_s) begin
      inc_s1_q <= increase_duty;
      inc_s2_q <= inc_s1_q;
      dec_s1_q <= decrease_duty;
      dec_s2_q <= dec_s1_q;
    end
  end

  // Selected-channel shadow update: load beats presses, presses saturate
  always_comb begin
    sel_ok_s = ({1'b0, ch_sel} < (CH_W+1)'(NUM_CH));
    cur_s    = '0;
    if (sel_ok_s) begin
      cur_s = shadow_q[ch_sel];
    end else begin
      cur_s = '0;
    end
    sum_s    = {1'b0, cur_s} + STEP_W;
    wr_en_s  = 1'b0;
    wr_val_s = cur_s;
    if (load_en) begin
      wr_en_s  = 1'b1;
      wr_val_s = ({1'b0, load_duty} > MAX_DUTY_W) ? MAX_DUTY : load_duty;
    end else if (inc_press_s && !dec_press_s) begin
      wr_en_s  = 1'b1;
      wr_val_s = (sum_s > MAX_DUTY_W) ? MAX_DUTY : sum_s[CNT_W-1:0];
    end else if (dec_press_s && !inc_press_s) begin
      wr_en_s  = 1'b1;
      wr_val_s = ({1'b0, cur_s} > STEP_W) ? CNT_W'({1'b0, cur_s} - STEP_W) : '0;
    end else begin
      wr_en_s  = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ok_s && wr_en_s && (ch_sel == CH_W'(i))) begin
        shadow_d[i] = wr_val_s;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
  end

  // Next counter value for edge (sawtooth) or centre (triangle) counting
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!mode_q) begin
      dir_d = 1'b0;
      if (cnt_q == PMAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!dir_q) begin
      if (cnt_q == PMAX) begin
        cnt_d = PMAX - CNT_W'(1);
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d = '0;
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Period boundary latching; compare against the duty taking effect now
  always_comb begin
    mode_d = boundary_s ? center_mode : mode_q;
    pwm_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (boundary_s) begin
        active_d[i] = shadow_q[i];
      end else begin
        active_d[i] = active_q[i];
      end
      pwm_d[i] = (cnt_q < active_d[i]);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= INIT_D;
        active_q[i] <= INIT_D;
      end
      cnt_q          <= '0;
      dir_q          <= 1'b0;
      mode_q         <= 1'b0;
      pwm_q          <= '0;
      duty_rd_q      <= INIT_D;
      period_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      pwm_q          <= pwm_d;
      duty_rd_q      <= cur_s;
      period_start_q <= boundary_s;
    end
  end

  assign PWM_OUT      = pwm_q;
  assign duty_rd      = duty_rd_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel with a small configuration.
// Expected per-cycle waveforms are derived from duty/mode and queued before
// each measured period, then popped and compared as the DUT produces them.
module tb_pwm_multi_channel;
  localparam int NCH = 2;
  localparam int CW  = 4;
  localparam int P   = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [0:0]    ch_sel = 1'b0;
  logic          increase_duty = 1'b0;
  logic          decrease_duty = 1'b0;
  logic          load_en = 1'b0;
  logic [CW-1:0] load_duty = '0;
  logic          center_mode = 1'b0;
  logic [NCH-1:0] PWM_OUT;
  logic [CW-1:0] duty_rd;
  logic          period_start;

  int checks = 0;
  int errors = 0;
  int unsigned cyc;
  logic [2:0] exp_q[$];
  logic cm_next = 1'b0;
  logic ld_next = 1'b0;
  logic [CW-1:0] ld_val = '0;

  pwm_multi_channel #(
    .NUM_CH(NCH), .CNT_W(CW), .PERIOD(P), .STEP(1), .INIT_DUTY(5), .DEBOUNCE_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel),
    .increase_duty(increase_duty), .decrease_duty(decrease_duty),
    .load_en(load_en), .load_duty(load_duty), .center_mode(center_mode),
    .PWM_OUT(PWM_OUT), .duty_rd(duty_rd), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Cycles since reset release, used to find debounce tick edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic exp_bit(input logic m, input int k, input int d);
    int cv;
    cv = (m && k > P) ? (2 * P - k) : k;
    return (cv < d);
  endfunction

  // Measure one full period starting at the next period_start
  task automatic measure(input logic m, input int d0, input int d1, input int act_k);
    int len;
    int n;
    logic [2:0] e;
    logic [2:0] o;
    len = m ? 2 * P : P + 1;
    n = 0;
    while (period_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("period_start_seen", {31'd0, period_start}, 32'd1);
    for (int k = 0; k < len; k++)
      exp_q.push_back({(k == 0), exp_bit(m, k, d1), exp_bit(m, k, d0)});
    for (int k = 0; k < len; k++) begin
      if (k == act_k) begin
        center_mode = cm_next;
        if (ld_next) begin
          load_duty = ld_val;
          load_en = 1'b1;
        end
      end else begin
        load_en = 1'b0;
      end
      e = exp_q.pop_front();
      o = {period_start, PWM_OUT};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL wave_k%0d observed %b expected %b", k, o, e);
      end
      @(negedge clk);
    end
    load_en = 1'b0;
    check("period_len", {31'd0, period_start}, 32'd1);
  endtask

  task automatic press(input logic i, input logic d);
    increase_duty = i;
    decrease_duty = d;
    repeat (16) @(negedge clk);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic load(input logic [CW-1:0] v);
    load_duty = v;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pwm", {30'd0, PWM_OUT}, 32'd0);
    check("rst_duty_rd", {28'd0, duty_rd}, 32'd5);
    check("rst_period_start", {31'd0, period_start}, 32'd0);
    rst_n = 1'b1;

    // Idle edge-aligned: 5 of 10 on both channels
    measure(1'b0, 5, 5, -1);
    measure(1'b0, 5, 5, -1);
    check("idle_duty_rd", {28'd0, duty_rd}, 32'd5);

    // Bouncing increment on channel 1: exactly one step
    ch_sel = 1'b1;
    @(negedge clk);
    increase_duty = 1'b1; @(negedge clk);
    increase_duty = 1'b0; @(negedge clk);
    increase_duty = 1'b1;
    repeat (20) @(negedge clk);
    check("inc_once", {28'd0, duty_rd}, 32'd6);
    repeat (30) @(negedge clk);
    check("inc_hold_no_repeat", {28'd0, duty_rd}, 32'd6);
    increase_duty = 1'b0;
    repeat (16) @(negedge clk);

    // Mid-period load of ch1 leaves current period untouched
    cm_next = 1'b0; ld_next = 1'b1; ld_val = 4'd2;
    measure(1'b0, 5, 6, 4);
    ld_next = 1'b0;
    measure(1'b0, 5, 2, -1);

    // Load saturates at PERIOD+1, then decrements floor at 0
    ch_sel = 1'b0;
    @(negedge clk);
    load(4'd15);
    check("load_clamp", {28'd0, duty_rd}, 32'd10);
    measure(1'b0, 10, 2, -1);
    for (int i = 0; i < 11; i++) press(1'b0, 1'b1);
    check("dec_floor", {28'd0, duty_rd}, 32'd0);
    measure(1'b0, 0, 2, -1);

    // Centre mode requested mid-period takes effect next period
    load(4'd3);
    check("load_3", {28'd0, duty_rd}, 32'd3);
    cm_next = 1'b1;
    measure(1'b0, 3, 2, 4);
    measure(1'b1, 3, 2, -1);
    measure(1'b1, 3, 2, -1);

    // Simultaneous increment and decrement: no change
    press(1'b1, 1'b1);
    check("inc_dec_same_tick", {28'd0, duty_rd}, 32'd3);

    // Load in the same cycle as an increment press: load wins
    increase_duty = 1'b1;
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    repeat (3) @(negedge clk);
    load_duty = 4'd2;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    check("load_beats_press", {28'd0, duty_rd}, 32'd2);
    increase_duty = 1'b0;
    repeat (16) @(negedge clk);
    check("load_beats_press_hold", {28'd0, duty_rd}, 32'd2);

    // Asynchronous reset while PWM_OUT[0] is high
    begin
      int n;
      n = 0;
      while (PWM_OUT[0] !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("pwm0_high_before_reset", {31'd0, PWM_OUT[0]}, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", {30'd0, PWM_OUT}, 32'd0);
    check("async_rst_duty_rd", {28'd0, duty_rd}, 32'd5);
    check("async_rst_period_start", {31'd0, period_start}, 32'd0);
    @(negedge clk);
    center_mode = 1'b0;
    ch_sel = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_duty_rd_ch1", {28'd0, duty_rd}, 32'd5);
    measure(1'b0, 5, 5, -1);
    measure(1'b0, 5, 5, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
